// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared types and constants for the skid-buffered pipeline stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // Number of held entries implied by a state.
    function automatic logic [1:0] state_occ(input pipe_state_t st);
        case (st)
            ST_FULL: state_occ = 2'd1;
            ST_SKID: state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
// ============================================================================
// Module  : pipe_entry_reg
// Purpose : Load-enabled ctrl/data/address entry register, async reset to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 2 * XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] rd_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] rd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
            rd_q   <= rd_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;
    assign rd_o   = rd_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module  : pipe_stage_skid
// Purpose : Valid/ready pipeline stage register with a 2-entry skid buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = 4,
    parameter int DATA_W    = 2 * XLEN,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit ZERO_CTRL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_rd_o,
    output logic [1:0]        occ_o
);

    pipe_state_t state_q, state_d;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [1:0]  occ_q;

    logic        in_fire;
    logic        out_fire;
    logic        main_load;
    logic        skid_load;
    logic        main_from_skid;

    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data_d, main_data, skid_data;
    logic [ADDR_W-1:0] main_rd_d,   main_rd,   skid_rd;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i & ~stall_i;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        // Flush drops everything, including a beat accepted this same cycle.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d        = ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so out_ready_i
    // and stall_i never reach in_ready_o combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_SKID);
            out_valid_q <= (state_d != ST_EMPTY);
            occ_q       <= state_occ(state_d);
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;
    assign main_data_d = main_from_skid ? skid_data : in_data_i;
    assign main_rd_d   = main_from_skid ? skid_rd   : in_rd_i;

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (main_load),
        .ctrl_i (main_ctrl_d),
        .data_i (main_data_d),
        .rd_i   (main_rd_d),
        .ctrl_o (main_ctrl),
        .data_o (main_data),
        .rd_o   (main_rd)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (skid_load),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .rd_i   (in_rd_i),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data),
        .rd_o   (skid_rd)
    );

    generate
        if (ZERO_CTRL) begin : g_ctrl_mask
            assign out_ctrl_o = out_valid_q ? main_ctrl : '0;
        end else begin : g_ctrl_raw
            assign out_ctrl_o = main_ctrl;
        end
    endgenerate

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_data;
    assign out_rd_o    = main_rd;
    assign occ_o       = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module  : tb_pipe_stage_skid
// Purpose : Directed vector table plus async-reset sequences for pipe_stage_skid.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [3:0]  in_ctrl_i = '0;
    logic [63:0] in_data_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [3:0]  out_ctrl_o;
    logic [63:0] out_data_o;
    logic [4:0]  out_rd_o;
    logic [1:0]  occ_o;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid #(
        .CTRL_W    (4),
        .DATA_W    (64),
        .ADDR_W    (5),
        .ZERO_CTRL (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .in_rd_i     (in_rd_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .out_rd_o    (out_rd_o),
        .occ_o       (occ_o)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        vld;
        logic        rdy;
        logic [3:0]  ctrl;
        logic [63:0] data;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [3:0]  e_ctrl;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic flush, input logic stall,
                       input logic vld, input logic rdy, input logic [3:0] ctrl,
                       input logic [63:0] data, input logic e_ov, input logic e_ir,
                       input logic [1:0] e_occ, input logic [3:0] e_ctrl,
                       input logic [63:0] e_data);
        vec_t v;
        v.rst = rst; v.flush = flush; v.stall = stall; v.vld = vld; v.rdy = rdy;
        v.ctrl = ctrl; v.data = data;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_ctrl = e_ctrl; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    // The address channel rides along as data[4:0] so one field pins both.
    task automatic check(input string name, input logic e_ov, input logic e_ir,
                         input logic [1:0] e_occ, input logic [3:0] e_ctrl,
                         input logic [63:0] e_data);
        logic [4:0] e_rd;
        e_rd = e_data[4:0];
        n_vec++;
        if (out_valid_o !== e_ov || in_ready_o !== e_ir || occ_o !== e_occ ||
            out_ctrl_o !== e_ctrl || out_data_o !== e_data || out_rd_o !== e_rd) begin
            n_bad++;
            $display("FAIL %s: got ov=%b ir=%b occ=%0d ctrl=%h data=%h rd=%h ; want ov=%b ir=%b occ=%0d ctrl=%h data=%h rd=%h",
                     name, out_valid_o, in_ready_o, occ_o, out_ctrl_o, out_data_o, out_rd_o,
                     e_ov, e_ir, e_occ, e_ctrl, e_data, e_rd);
        end
    endtask

    task automatic drive(input logic flush, input logic stall, input logic vld,
                         input logic rdy, input logic [3:0] ctrl, input logic [63:0] data);
        flush_i     = flush;
        stall_i     = stall;
        in_valid_i  = vld;
        out_ready_i = rdy;
        in_ctrl_i   = ctrl;
        in_data_i   = data;
        in_rd_i     = data[4:0];
    endtask

    initial begin
        // rst flush stall vld rdy ctrl data | ov ir occ ctrl data
        add(1, 0, 0, 0, 0, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h0);
        // Back-to-back streaming, one-cycle lag
        for (int k = 1; k <= 8; k++)
            add(0, 0, 0, 1, 1, 4'(k), 64'(k), 1, 1, 1, 4'(k), 64'(k));
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h8);
        // Skid: A held, B lands in skid, C refused until space
        add(0, 0, 0, 1, 0, 4'h3, 64'hA,  1, 1, 1, 4'h3, 64'hA);
        add(0, 0, 0, 1, 0, 4'h5, 64'hB,  1, 0, 2, 4'h3, 64'hA);
        add(0, 0, 0, 1, 0, 4'h6, 64'hC,  1, 0, 2, 4'h3, 64'hA);
        add(0, 0, 0, 1, 1, 4'h6, 64'hC,  1, 1, 1, 4'h5, 64'hB);
        add(0, 0, 0, 1, 1, 4'h6, 64'hC,  1, 1, 1, 4'h6, 64'hC);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'hC);
        // Stall with out_ready high
        add(0, 0, 0, 1, 1, 4'h7, 64'hD,  1, 1, 1, 4'h7, 64'hD);
        add(0, 0, 1, 1, 1, 4'h8, 64'hE,  1, 0, 2, 4'h7, 64'hD);
        add(0, 0, 1, 0, 1, 4'h0, 64'h0,  1, 0, 2, 4'h7, 64'hD);
        add(0, 0, 1, 0, 1, 4'h0, 64'h0,  1, 0, 2, 4'h7, 64'hD);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  1, 1, 1, 4'h8, 64'hE);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'hE);
        // Flush from SKID
        add(0, 0, 0, 1, 0, 4'h9, 64'h11, 1, 1, 1, 4'h9, 64'h11);
        add(0, 0, 0, 1, 0, 4'hA, 64'h12, 1, 0, 2, 4'h9, 64'h11);
        add(0, 1, 0, 1, 0, 4'hC, 64'h1F, 0, 1, 0, 4'h0, 64'h11);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h11);
        // Flush from FULL with a beat accepted in the same cycle
        add(0, 0, 0, 1, 0, 4'hB, 64'h13, 1, 1, 1, 4'hB, 64'h13);
        add(0, 1, 0, 1, 0, 4'hD, 64'h14, 0, 1, 0, 4'h0, 64'h13);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h13);
        // Flush beats stall
        add(0, 0, 0, 1, 0, 4'h2, 64'h15, 1, 1, 1, 4'h2, 64'h15);
        add(0, 1, 1, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h15);
        // Bubble masking of ctrl
        add(0, 0, 0, 1, 1, 4'hF, 64'h20, 1, 1, 1, 4'hF, 64'h20);
        add(0, 0, 0, 0, 1, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h20);
        add(0, 0, 0, 0, 0, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h20);

        repeat (2) @(posedge clk_i);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            rst_i = vecs[i].rst;
            drive(vecs[i].flush, vecs[i].stall, vecs[i].vld, vecs[i].rdy,
                  vecs[i].ctrl, vecs[i].data);
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ,
                  vecs[i].e_ctrl, vecs[i].e_data);
        end

        // Async reset while FULL: outputs drop before any clock edge
        @(negedge clk_i);
        drive(0, 0, 1, 0, 4'h4, 64'h33);
        @(posedge clk_i);
        #1;
        check("load_before_rst", 1, 1, 1, 4'h4, 64'h33);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 4'h0, 64'h0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_full", 0, 1, 0, 4'h0, 64'h0);

        // Async reset while SKID
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 1, 0, 4'h1, 64'h41);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        drive(0, 0, 1, 0, 4'h2, 64'h42);
        @(posedge clk_i);
        #1;
        check("skid_before_rst", 1, 0, 2, 4'h1, 64'h41);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_skid", 0, 1, 0, 4'h0, 64'h0);

        // After reset release, the pre-reset skid beat must not reappear
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 0, 1, 4'h0, 64'h0);
        @(posedge clk_i);
        #1;
        check("post_rst_idle", 0, 1, 0, 4'h0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
